// File: rtl/fp_addsub_pipe_pkg.sv
// Shared definitions for the pipelined floating-point adder/subtractor.
//   Flag bit positions within the 4-bit flags word {invalid, overflow, underflow, inexact},
//   the operand classification enum, and a canonical quiet-NaN builder usable for any
//   exponent/mantissa width up to 64 bits total.
package fp_addsub_pipe_pkg;

    localparam int unsigned FlagW         = 4;
    localparam int unsigned FlagInvalid   = 3;
    localparam int unsigned FlagOverflow  = 2;
    localparam int unsigned FlagUnderflow = 1;
    localparam int unsigned FlagInexact   = 0;

    typedef enum logic [2:0] {
        ClsZero,
        ClsNorm,
        ClsInf,
        ClsQnan,
        ClsSnan
    } fp_class_e;

    // Canonical qNaN: sign 0, exponent all ones, mantissa MSB set, rest zero.
    // Callers truncate the result to their word width.
    function automatic logic [63:0] qnan(input int unsigned exp_w, input int unsigned man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_addsub_pipe_if.sv
// Streaming operand/result bus for fp_addsub_pipe.
//   in_valid/in_ready  : operand beat handshake (a, b, sub)
//   out_valid/out_ready: result beat handshake (result, flags)
//   master modport drives operands and consumes results; slave is the datapath side.
interface fp_addsub_pipe_if
    import fp_addsub_pipe_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result;
    logic [FlagW-1:0] flags;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, flags
    );

endinterface

// File: rtl/fp_addsub_pipe_lzc.sv
// Leading-zero counter.
//   in_i  : WIDTH-bit vector
//   cnt_o : number of zeros above the most significant set bit (WIDTH when in_i is zero)
module fp_lzc #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Ascending scan: the highest set bit is the last to write.
    always_comb begin
        cnt_o = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (in_i[i]) begin
                cnt_o = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Pipelined IEEE-754 adder/subtractor, round-to-nearest-even, flush-to-zero.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset, clears valids, result and flags
//   bus   : slave side of fp_addsub_pipe_if (operands a/b/sub in, result/flags out)
// Register ranks: operand capture, S1 unpack/align, S2 add, S3 normalise/round/pack.
// All ranks advance together when the output is empty or being consumed.
module fp_addsub_pipe
    import fp_addsub_pipe_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input logic             clk,
    input logic             rst_n,
    fp_addsub_pipe_if.slave bus
);

    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned MW   = MAN_W + 4;  // {hidden, mantissa, guard, round, sticky}
    localparam int unsigned EW2  = EXP_W + 2;  // room for carry and a sign bit on underflow
    localparam int unsigned LzcW = $clog2(MW + 1);
    localparam logic [EXP_W-1:0] ExpMax = '1;
    localparam logic [W-1:0]     QNaN   = W'(qnan(EXP_W, MAN_W));

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == ExpMax) begin
            if (m == '0) return ClsInf;
            else if (m[MAN_W-1]) return ClsQnan;
            else return ClsSnan;
        end else if (e == '0) begin
            return ClsZero;
        end
        return ClsNorm;
    endfunction

    logic en;
    logic out_valid_q;
    assign en           = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = en;

    // ---------------- operand capture ----------------
    logic         v0_q, sub0_q;
    logic [W-1:0] a0_q, b0_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q   <= 1'b0;
            a0_q   <= '0;
            b0_q   <= '0;
            sub0_q <= 1'b0;
        end else if (en) begin
            v0_q   <= bus.in_valid;
            a0_q   <= bus.a;
            b0_q   <= bus.b;
            sub0_q <= bus.sub;
        end
    end

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic             sgn_a, sgn_b;
    logic [EXP_W-1:0] exp_a, exp_b, ex, ey, d;
    logic [MAN_W-1:0] man_af, man_bf, mxm, mym;
    fp_class_e        cls_a, cls_b;
    logic             swap, sx, sy;
    logic [MW-1:0]    mx_ext, my_ext, my_al, lost_mask;

    assign sgn_a  = a0_q[W-1];
    assign sgn_b  = b0_q[W-1] ^ sub0_q;
    assign exp_a  = a0_q[W-2:MAN_W];
    assign exp_b  = b0_q[W-2:MAN_W];
    assign cls_a  = classify(exp_a, a0_q[MAN_W-1:0]);
    assign cls_b  = classify(exp_b, b0_q[MAN_W-1:0]);
    // Denormals become signed zero by dropping their mantissa.
    assign man_af = (exp_a == '0) ? '0 : a0_q[MAN_W-1:0];
    assign man_bf = (exp_b == '0) ? '0 : b0_q[MAN_W-1:0];

    assign swap   = {exp_b, man_bf} > {exp_a, man_af};
    assign ex     = swap ? exp_b  : exp_a;
    assign ey     = swap ? exp_a  : exp_b;
    assign mxm    = swap ? man_bf : man_af;
    assign mym    = swap ? man_af : man_bf;
    assign sx     = swap ? sgn_b  : sgn_a;
    assign sy     = swap ? sgn_a  : sgn_b;
    assign mx_ext = {|ex, mxm, 3'b000};
    assign my_ext = {|ey, mym, 3'b000};
    assign d      = ex - ey;
    assign lost_mask = ~({MW{1'b1}} << d);

    always_comb begin
        if (32'(d) >= MAN_W + 3) begin
            my_al = {{(MW-1){1'b0}}, |my_ext};
        end else begin
            my_al = (my_ext >> d) | {{(MW-1){1'b0}}, |(my_ext & lost_mask)};
        end
    end

    // NaN/Inf results are fully decided here and bypass the arithmetic.
    logic             a_nan, b_nan, a_inf, b_inf;
    logic             sp_d;
    logic [W-1:0]     sres_d;
    logic [FlagW-1:0] sflg_d;

    assign a_nan = (cls_a == ClsQnan) || (cls_a == ClsSnan);
    assign b_nan = (cls_b == ClsQnan) || (cls_b == ClsSnan);
    assign a_inf = (cls_a == ClsInf);
    assign b_inf = (cls_b == ClsInf);

    always_comb begin
        sp_d   = 1'b1;
        sres_d = QNaN;
        sflg_d = '0;
        if (a_nan || b_nan) begin
            sflg_d[FlagInvalid] = (cls_a == ClsSnan) || (cls_b == ClsSnan);
        end else if (a_inf && b_inf && (sgn_a != sgn_b)) begin
            sflg_d[FlagInvalid] = 1'b1;
        end else if (a_inf) begin
            sres_d = {sgn_a, ExpMax, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            sres_d = {sgn_b, ExpMax, {MAN_W{1'b0}}};
        end else begin
            sp_d = 1'b0;
        end
    end

    logic             v1_q, sx1_q, sy1_q, sp1_q;
    logic [EXP_W-1:0] ex1_q;
    logic [MW-1:0]    mx1_q, my1_q;
    logic [W-1:0]     sres1_q;
    logic [FlagW-1:0] sflg1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            sx1_q   <= 1'b0;
            sy1_q   <= 1'b0;
            sp1_q   <= 1'b0;
            ex1_q   <= '0;
            mx1_q   <= '0;
            my1_q   <= '0;
            sres1_q <= '0;
            sflg1_q <= '0;
        end else if (en) begin
            v1_q    <= v0_q;
            sx1_q   <= sx;
            sy1_q   <= sy;
            sp1_q   <= sp_d;
            ex1_q   <= ex;
            mx1_q   <= mx_ext;
            my1_q   <= my_al;
            sres1_q <= sres_d;
            sflg1_q <= sflg_d;
        end
    end

    // ---------------- S2: add / subtract magnitudes ----------------
    logic [MW:0] sum;
    logic        sign2;

    // |X| >= |Y| so the difference never goes negative.
    assign sum   = (sx1_q ^ sy1_q) ? ({1'b0, mx1_q} - {1'b0, my1_q})
                                   : ({1'b0, mx1_q} + {1'b0, my1_q});
    // Exact zero is +0 unless both operands were negative.
    assign sign2 = (sum == '0) ? (sx1_q & sy1_q) : sx1_q;

    logic             v2_q, sign2_q, sp2_q;
    logic [EXP_W-1:0] ex2_q;
    logic [MW:0]      sum2_q;
    logic [W-1:0]     sres2_q;
    logic [FlagW-1:0] sflg2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            sign2_q <= 1'b0;
            sp2_q   <= 1'b0;
            ex2_q   <= '0;
            sum2_q  <= '0;
            sres2_q <= '0;
            sflg2_q <= '0;
        end else if (en) begin
            v2_q    <= v1_q;
            sign2_q <= sign2;
            sp2_q   <= sp1_q;
            ex2_q   <= ex1_q;
            sum2_q  <= sum;
            sres2_q <= sres1_q;
            sflg2_q <= sflg1_q;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [LzcW-1:0]  lz;
    logic [MW-1:0]    norm;
    logic [EW2-1:0]   exp_n, exp_r;
    logic [MAN_W+1:0] mant_r;
    logic [MAN_W-1:0] man_out;
    logic             rnd, carry_r, uf, of;

    fp_lzc #(
        .WIDTH (MW),
        .CNT_W (LzcW)
    ) u_lzc (
        .in_i  (sum2_q[MW-1:0]),
        .cnt_o (lz)
    );

    always_comb begin
        if (sum2_q[MW]) begin
            // Carry out: shift right one, folding the dropped bit into sticky.
            norm  = {sum2_q[MW:2], |sum2_q[1:0]};
            exp_n = {2'b00, ex2_q} + EW2'(1);
        end else begin
            norm  = sum2_q[MW-1:0] << lz;
            exp_n = {2'b00, ex2_q} - EW2'(lz);
        end
    end

    assign rnd     = norm[2] & (norm[1] | norm[0] | norm[3]);
    assign mant_r  = {1'b0, norm[MW-1:3]} + {{(MAN_W+1){1'b0}}, rnd};
    assign carry_r = mant_r[MAN_W+1];
    assign man_out = carry_r ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    assign exp_r   = exp_n + {{(EW2-1){1'b0}}, carry_r};
    assign uf      = exp_n[EW2-1] | (exp_n == '0);
    assign of      = ~uf & (exp_r >= {2'b00, ExpMax});

    logic [W-1:0]     res_d;
    logic [FlagW-1:0] flg_d;

    always_comb begin
        res_d              = {sign2_q, exp_r[EXP_W-1:0], man_out};
        flg_d              = '0;
        flg_d[FlagInexact] = |norm[2:0];
        if (sp2_q) begin
            res_d = sres2_q;
            flg_d = sflg2_q;
        end else if (sum2_q == '0) begin
            res_d = {sign2_q, {(W-1){1'b0}}};
            flg_d = '0;
        end else if (uf) begin
            res_d                = {sign2_q, {(W-1){1'b0}}};
            flg_d                = '0;
            flg_d[FlagUnderflow] = 1'b1;
            flg_d[FlagInexact]   = 1'b1;
        end else if (of) begin
            res_d               = {sign2_q, ExpMax, {MAN_W{1'b0}}};
            flg_d               = '0;
            flg_d[FlagOverflow] = 1'b1;
            flg_d[FlagInexact]  = 1'b1;
        end
    end

    logic [W-1:0]     result_q;
    logic [FlagW-1:0] flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (en) begin
            out_valid_q <= v2_q;
            result_q    <= res_d;
            flags_q     <= flg_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: single-precision instance plus a half-precision instance.
module tb_fp_addsub_pipe;

    logic clk;
    logic rst_n;
    int   nvec;
    int   nmis;

    fp_addsub_pipe_if #(.EXP_W(8), .MAN_W(23)) sp ();
    fp_addsub_pipe_if #(.EXP_W(5), .MAN_W(10)) hp ();

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) u_sp (.clk(clk), .rst_n(rst_n), .bus(sp));
    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) u_hp (.clk(clk), .rst_n(rst_n), .bus(hp));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One beat through an otherwise idle pipe; lat counts edges after the accepting edge.
    task automatic run_sp(input logic [31:0] opa, input logic [31:0] opb, input logic s,
                          output logic [31:0] r, output logic [3:0] f, output int lat);
        sp.a = opa; sp.b = opb; sp.sub = s; sp.in_valid = 1'b1; sp.out_ready = 1'b1;
        step();
        sp.in_valid = 1'b0;
        lat = 0;
        while (sp.out_valid !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        r = sp.result;
        f = sp.flags;
    endtask

    task automatic run_hp(input logic [15:0] opa, input logic [15:0] opb, input logic s,
                          output logic [15:0] r, output logic [3:0] f, output int lat);
        hp.a = opa; hp.b = opb; hp.sub = s; hp.in_valid = 1'b1; hp.out_ready = 1'b1;
        step();
        hp.in_valid = 1'b0;
        lat = 0;
        while (hp.out_valid !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        r = hp.result;
        f = hp.flags;
    endtask

    task automatic drain_sp();
        sp.in_valid = 1'b0;
        sp.out_ready = 1'b1;
        repeat (5) step();
    endtask

    task automatic test_reset();
        repeat (2) step();
        nvec++; if (sp.out_valid !== 1'b0) begin nmis++;
            $display("FAIL reset out_valid: got %b want 0", sp.out_valid); end
        nvec++; if (sp.result !== 32'h0) begin nmis++;
            $display("FAIL reset result: got %h want 00000000", sp.result); end
        nvec++; if (sp.flags !== 4'h0) begin nmis++;
            $display("FAIL reset flags: got %b want 0000", sp.flags); end
        rst_n = 1'b1;
        step();
        nvec++; if (sp.in_ready !== 1'b1) begin nmis++;
            $display("FAIL post-reset in_ready: got %b want 1", sp.in_ready); end
        nvec++; if (sp.out_valid !== 1'b0) begin nmis++;
            $display("FAIL post-reset out_valid: got %b want 0", sp.out_valid); end
    endtask

    task automatic test_basic();
        logic [31:0] r; logic [3:0] f; int lat;
        run_sp(32'h3F800000, 32'h40000000, 1'b0, r, f, lat);
        nvec++; if (lat !== 3) begin nmis++;
            $display("FAIL latency: got %0d edges want 3", lat); end
        nvec++; if (r !== 32'h40400000) begin nmis++;
            $display("FAIL 1+2 result: got %h want 40400000", r); end
        nvec++; if (f !== 4'b0000) begin nmis++;
            $display("FAIL 1+2 flags: got %b want 0000", f); end
    endtask

    task automatic test_zero();
        logic [31:0] r; logic [3:0] f; int lat;
        run_sp(32'h40400000, 32'h40400000, 1'b1, r, f, lat);
        nvec++; if (r !== 32'h00000000 || f !== 4'b0000) begin nmis++;
            $display("FAIL 3-3: got %h/%b want 00000000/0000", r, f); end
        run_sp(32'h80000000, 32'h80000000, 1'b0, r, f, lat);
        nvec++; if (r !== 32'h80000000 || f !== 4'b0000) begin nmis++;
            $display("FAIL -0+-0: got %h/%b want 80000000/0000", r, f); end
        run_sp(32'h00000000, 32'h80000000, 1'b0, r, f, lat);
        nvec++; if (r !== 32'h00000000 || f !== 4'b0000) begin nmis++;
            $display("FAIL +0+-0: got %h/%b want 00000000/0000", r, f); end
        run_sp(32'h00000001, 32'h3F800000, 1'b0, r, f, lat);
        nvec++; if (r !== 32'h3F800000 || f !== 4'b0000) begin nmis++;
            $display("FAIL denorm flush: got %h/%b want 3F800000/0000", r, f); end
    endtask

    task automatic test_overflow_underflow();
        logic [31:0] r; logic [3:0] f; int lat;
        run_sp(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, r, f, lat);
        nvec++; if (r !== 32'h7F800000 || f !== 4'b0101) begin nmis++;
            $display("FAIL overflow: got %h/%b want 7F800000/0101", r, f); end
        run_sp(32'h00800001, 32'h00800000, 1'b1, r, f, lat);
        nvec++; if (r !== 32'h00000000 || f !== 4'b0011) begin nmis++;
            $display("FAIL underflow: got %h/%b want 00000000/0011", r, f); end
    endtask

    task automatic test_specials();
        logic [31:0] r; logic [3:0] f; int lat;
        run_sp(32'h7F800000, 32'h7F800000, 1'b1, r, f, lat);
        nvec++; if (r !== 32'h7FC00000 || f !== 4'b1000) begin nmis++;
            $display("FAIL inf-inf: got %h/%b want 7FC00000/1000", r, f); end
        run_sp(32'h7FA00000, 32'h3F800000, 1'b0, r, f, lat);
        nvec++; if (r !== 32'h7FC00000 || f !== 4'b1000) begin nmis++;
            $display("FAIL snan: got %h/%b want 7FC00000/1000", r, f); end
        run_sp(32'h7FC00001, 32'h3F800000, 1'b0, r, f, lat);
        nvec++; if (r !== 32'h7FC00000 || f !== 4'b0000) begin nmis++;
            $display("FAIL qnan: got %h/%b want 7FC00000/0000", r, f); end
        run_sp(32'hFF800000, 32'h3F800000, 1'b0, r, f, lat);
        nvec++; if (r !== 32'hFF800000 || f !== 4'b0000) begin nmis++;
            $display("FAIL -inf+1: got %h/%b want FF800000/0000", r, f); end
        run_sp(32'h3F800000, 32'h7F800000, 1'b1, r, f, lat);
        nvec++; if (r !== 32'hFF800000 || f !== 4'b0000) begin nmis++;
            $display("FAIL 1-inf: got %h/%b want FF800000/0000", r, f); end
    endtask

    task automatic test_rne();
        logic [31:0] r; logic [3:0] f; int lat;
        run_sp(32'h3F800000, 32'h33800000, 1'b0, r, f, lat);
        nvec++; if (r !== 32'h3F800000 || f !== 4'b0001) begin nmis++;
            $display("FAIL tie even: got %h/%b want 3F800000/0001", r, f); end
        run_sp(32'h3F800001, 32'h33800000, 1'b0, r, f, lat);
        nvec++; if (r !== 32'h3F800002 || f !== 4'b0001) begin nmis++;
            $display("FAIL tie odd: got %h/%b want 3F800002/0001", r, f); end
        run_sp(32'h3F800000, 32'h33C00000, 1'b0, r, f, lat);
        nvec++; if (r !== 32'h3F800001 || f !== 4'b0001) begin nmis++;
            $display("FAIL above half: got %h/%b want 3F800001/0001", r, f); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic [31:0] ve [6];
        logic        vs [6];
        int idx, oidx, extra;
        va = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h3FC00000, 32'hBF800000};
        vb = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F800000, 32'h3FC00000, 32'h3F000000};
        vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ve = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40000000, 32'h40400000, 32'hBF000000};
        drain_sp();
        idx = 0;
        oidx = 0;
        for (int cyc = 0; cyc < 60 && oidx < 6; cyc++) begin
            sp.out_ready = !(cyc >= 5 && cyc < 10);
            if (idx < 6) begin
                sp.in_valid = 1'b1; sp.a = va[idx]; sp.b = vb[idx]; sp.sub = vs[idx];
            end else begin
                sp.in_valid = 1'b0;
            end
            #1;
            if (sp.out_ready === 1'b0 && sp.out_valid === 1'b1) begin
                nvec++; if (sp.in_ready !== 1'b0) begin nmis++;
                    $display("FAIL stall in_ready cyc %0d: got %b want 0", cyc, sp.in_ready); end
                nvec++; if (sp.result !== ve[oidx]) begin nmis++;
                    $display("FAIL stall hold cyc %0d: got %h want %h", cyc, sp.result, ve[oidx]); end
            end
            if (sp.out_valid === 1'b1 && sp.out_ready === 1'b1) begin
                nvec++; if (sp.result !== ve[oidx] || sp.flags !== 4'b0000) begin nmis++;
                    $display("FAIL stream beat %0d: got %h/%b want %h/0000",
                             oidx, sp.result, sp.flags, ve[oidx]); end
                oidx++;
            end
            if (sp.in_valid === 1'b1 && sp.in_ready === 1'b1) idx++;
            @(posedge clk);
            #1;
        end
        sp.in_valid = 1'b0;
        sp.out_ready = 1'b1;
        nvec++; if (oidx !== 6) begin nmis++;
            $display("FAIL stream count: got %0d results want 6", oidx); end
        extra = 0;
        repeat (5) begin
            #1;
            if (sp.out_valid === 1'b1) extra++;
            step();
        end
        nvec++; if (extra !== 0) begin nmis++;
            $display("FAIL stream duplicates: got %0d extra beats want 0", extra); end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] r; logic [3:0] f; int lat, stale;
        drain_sp();
        sp.out_ready = 1'b0;
        sp.in_valid = 1'b1; sp.a = 32'h3F800000; sp.b = 32'h40000000; sp.sub = 1'b0;
        repeat (6) step();
        nvec++; if (sp.out_valid !== 1'b1) begin nmis++;
            $display("FAIL pre-reset fill: got out_valid %b want 1", sp.out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        nvec++; if (sp.out_valid !== 1'b0) begin nmis++;
            $display("FAIL async reset out_valid: got %b want 0", sp.out_valid); end
        nvec++; if (sp.result !== 32'h0 || sp.flags !== 4'h0) begin nmis++;
            $display("FAIL async reset data: got %h/%b want 00000000/0000", sp.result, sp.flags); end
        sp.in_valid = 1'b0;
        sp.out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        stale = 0;
        repeat (8) begin
            step();
            if (sp.out_valid === 1'b1) stale++;
        end
        nvec++; if (stale !== 0) begin nmis++;
            $display("FAIL stale after reset: got %0d beats want 0", stale); end
        run_sp(32'h3F800000, 32'h3F800000, 1'b0, r, f, lat);
        nvec++; if (r !== 32'h40000000 || f !== 4'b0000) begin nmis++;
            $display("FAIL post-reset op: got %h/%b want 40000000/0000", r, f); end
    endtask

    task automatic test_half();
        logic [15:0] r; logic [3:0] f; int lat;
        run_hp(16'h3C00, 16'h4000, 1'b0, r, f, lat);
        nvec++; if (lat !== 3) begin nmis++;
            $display("FAIL half latency: got %0d edges want 3", lat); end
        nvec++; if (r !== 16'h4200 || f !== 4'b0000) begin nmis++;
            $display("FAIL half 1+2: got %h/%b want 4200/0000", r, f); end
        run_hp(16'h7BFF, 16'h7BFF, 1'b0, r, f, lat);
        nvec++; if (r !== 16'h7C00 || f !== 4'b0101) begin nmis++;
            $display("FAIL half overflow: got %h/%b want 7C00/0101", r, f); end
    endtask

    initial begin
        nvec = 0;
        nmis = 0;
        rst_n = 1'b0;
        sp.in_valid = 1'b0; sp.a = '0; sp.b = '0; sp.sub = 1'b0; sp.out_ready = 1'b1;
        hp.in_valid = 1'b0; hp.a = '0; hp.b = '0; hp.sub = 1'b0; hp.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_zero();
        test_overflow_underflow();
        test_specials();
        test_rne();
        test_back_to_back();
        test_reset_midstream();
        test_half();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
